// File: rtl/cache_evict_ctrl.sv
// cache_evict_ctrl: N-way set-associative miss controller (victim select, dirty writeback, line fill)
// Ports: miss_req/miss_ready/miss_addr accept a miss; tags/valid/dirty/plru describe the indexed set;
//   pmem_read/pmem_write/pmem_address/pmem_resp talk to the memory arbiter;
//   victim_way/load_line/done tell the datapath where and when to install the fetched line.
module cache_evict_ctrl #(
  parameter int WAYS = 4,
  parameter int ADDR_W = 16,
  parameter int TAG_W = 6,
  parameter int OFFSET_W = 5,
  localparam int IDX_W = ADDR_W - TAG_W - OFFSET_W,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_req,
  output logic                    miss_ready,
  input  logic [ADDR_W-1:0]       miss_addr,
  input  logic [WAYS*TAG_W-1:0]   tags,
  input  logic [WAYS-1:0]         valid,
  input  logic [WAYS-1:0]         dirty,
  input  logic [WAYS-2:0]         plru,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [ADDR_W-1:0]       pmem_address,
  input  logic                    pmem_resp,
  output logic [WAY_W-1:0]        victim_way,
  output logic                    load_line,
  output logic                    done
);
  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-OFFSET_W-1:0] line_q;
  logic [TAG_W-1:0] vtag_q;
  logic [WAY_W-1:0] victim_q, inv_way, lru_way, vict;
  logic inv_any, accept, wb;
  logic unused_offset;
  assign unused_offset = ^miss_addr[OFFSET_W-1:0];
  // lru_way accumulates the path bits MSB-first; at level l it holds the l-bit prefix,
  // so the heap node being visited is (2^l - 1) + prefix.
  always_comb begin
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    lru_way = '0;
    for (int l = 0; l < WAY_W; l++)
      lru_way = (lru_way << 1) | WAY_W'(plru[WAY_W'((1 << l) - 1) + lru_way]);
  end
  assign vict = inv_any ? inv_way : lru_way;
  assign wb = valid[vict] & dirty[vict];
  assign accept = (state_q == IDLE) & miss_req;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = miss_req ? (wb ? WB : FILL) : IDLE;
      WB:      state_d = pmem_resp ? FILL : WB;
      FILL:    state_d = pmem_resp ? DONE : FILL;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      line_q <= '0;
      vtag_q <= '0;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        line_q <= miss_addr[ADDR_W-1:OFFSET_W];
        vtag_q <= tags[vict*TAG_W +: TAG_W];
        victim_q <= vict;
      end
    end
  end
  assign miss_ready = state_q == IDLE;
  assign pmem_write = state_q == WB;
  assign pmem_read = state_q == FILL;
  // Writeback targets the victim's own line: its tag with the missed index.
  assign pmem_address = state_q == WB ? {vtag_q, line_q[IDX_W-1:0], {OFFSET_W{1'b0}}}
                      : state_q == FILL ? {line_q, {OFFSET_W{1'b0}}} : '0;
  assign load_line = (state_q == FILL) & pmem_resp;
  assign done = state_q == DONE;
  assign victim_way = victim_q;
endmodule

// File: tb/tb_cache_evict_ctrl.sv
// tb_cache_evict_ctrl: randomized self-checking bench against a transaction-level model
module tb_cache_evict_ctrl;
  logic clk = 1'b0, rst = 1'b1, miss_req = 1'b0, pmem_resp = 1'b0;
  logic [15:0] miss_addr = '0;
  logic [23:0] tags = '0;
  logic [3:0] valid = '0, dirty = '0;
  logic [2:0] plru = '0;
  logic miss_ready, pmem_read, pmem_write, load_line, done;
  logic [15:0] pmem_address;
  logic [1:0] victim_way;
  logic miss_req8 = 1'b0, pmem_resp8 = 1'b0;
  logic [15:0] miss_addr8 = '0;
  logic [47:0] tags8 = '0;
  logic [7:0] valid8 = '0, dirty8 = '0;
  logic [6:0] plru8 = '0;
  logic ready8, rd8, wr8, load8, done8;
  logic [15:0] addr8;
  logic [2:0] victim8;
  int checks = 0, errors = 0;

  cache_evict_ctrl dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .tags(tags), .valid(valid), .dirty(dirty), .plru(plru), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_resp(pmem_resp),
    .victim_way(victim_way), .load_line(load_line), .done(done)
  );

  cache_evict_ctrl #(.WAYS(8)) dut8 (
    .clk(clk), .rst(rst), .miss_req(miss_req8), .miss_ready(ready8), .miss_addr(miss_addr8),
    .tags(tags8), .valid(valid8), .dirty(dirty8), .plru(plru8), .pmem_read(rd8),
    .pmem_write(wr8), .pmem_address(addr8), .pmem_resp(pmem_resp8),
    .victim_way(victim8), .load_line(load8), .done(done8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ref_victim(input int ways, input logic [15:0] v, input logic [14:0] p);
    int n;
    for (int w = 0; w < ways; w++) if (!v[w]) return w;
    n = 0;
    while (n < ways - 1) n = p[n] ? 2 * n + 2 : 2 * n + 1;
    return n - (ways - 1);
  endfunction

  task automatic scramble();
    miss_req = 1'($urandom);
    miss_addr = 16'($urandom);
    tags = 24'($urandom);
    plru = 3'($urandom);
    valid = 4'($urandom);
    dirty = 4'($urandom);
  endtask

  task automatic phase(input logic is_wr, input logic [15:0] ea, input int lat, input int ev);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      scramble();
      pmem_resp = (k == lat);
      #1;
      chk("pmem_write", pmem_write, is_wr);
      chk("pmem_read", pmem_read, !is_wr);
      chk("pmem_address", pmem_address, ea);
      chk("load_line", load_line, !is_wr && k == lat);
      chk("miss_ready_busy", miss_ready, 0);
      chk("done_busy", done, 0);
      chk("victim_way", victim_way, ev);
    end
  endtask

  task automatic run_miss(input logic [3:0] v, input logic [3:0] d, input logic [2:0] p,
                          input logic [23:0] t, input logic [15:0] a, input int lw, input int lf);
    int ev;
    logic ewb;
    ev = ref_victim(4, {12'hFFF, v}, {12'h0, p});
    ewb = v[ev] & d[ev];
    @(negedge clk);
    valid = v; dirty = d; plru = p; tags = t; miss_addr = a; miss_req = 1'b1; pmem_resp = 1'b0;
    #1;
    chk("miss_ready_idle", miss_ready, 1);
    if (ewb) phase(1'b1, {t[ev*6 +: 6], a[9:5], 5'b0}, lw, ev);
    phase(1'b0, {a[15:5], 5'b0}, lf, ev);
    @(negedge clk);
    miss_req = 1'b0;
    pmem_resp = 1'($urandom);
    #1;
    chk("done", done, 1);
    chk("miss_ready_done", miss_ready, 0);
    chk("rw_done", {pmem_read, pmem_write, load_line}, 0);
    chk("addr_done", pmem_address, 0);
    @(negedge clk);
    pmem_resp = 1'($urandom);
    #1;
    chk("done_once", done, 0);
    chk("miss_ready_back", miss_ready, 1);
    chk("rw_idle", {pmem_read, pmem_write, load_line}, 0);
    chk("addr_idle", pmem_address, 0);
    chk("victim_hold", victim_way, ev);
  endtask

  initial begin
    rst = 1'b1;
    miss_req = 1'b1;
    miss_addr = 16'hABCD;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_ready", miss_ready, 1);
      chk("rst_rw", {pmem_read, pmem_write, load_line, done}, 0);
      chk("rst_addr", pmem_address, 0);
      chk("rst_victim", victim_way, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    miss_req = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk("idle_resp", {pmem_read, pmem_write, load_line, done, miss_ready}, 1);
    pmem_resp = 1'b0;
    run_miss(4'b1111, 4'b0000, 3'b010, 24'h123456, 16'hABCD, 0, 3);
    run_miss(4'b1111, 4'b1000, 3'b101, {6'h15, 18'h2A5A5}, 16'hABCD, 2, 1);
    run_miss(4'b1011, 4'b1111, 3'b000, 24'hFFFFFF, 16'h1234, 0, 0);
    for (int i = 0; i < 40; i++)
      run_miss(($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom), 4'($urandom), 3'($urandom),
               24'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    @(negedge clk);
    valid = 4'b1111; dirty = 4'b1000; plru = 3'b101; tags = {6'h15, 18'h0}; miss_addr = 16'hABCD;
    miss_req = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_wb_write", pmem_write, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    miss_req = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk("mid_rst_rw", {pmem_read, pmem_write, load_line, done}, 0);
    chk("mid_rst_ready", miss_ready, 1);
    chk("mid_rst_addr", pmem_address, 0);
    chk("mid_rst_victim", victim_way, 0);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("late_resp", {pmem_read, pmem_write, load_line, done, miss_ready}, 1);
    for (int i = 0; i < 12; i++) begin
      int ev;
      @(negedge clk);
      valid8 = (i == 0 || $urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      plru8 = (i == 0) ? 7'b0000101 : 7'($urandom);
      tags8 = 48'({$urandom, $urandom});
      miss_addr8 = 16'($urandom);
      miss_req8 = 1'b1;
      ev = ref_victim(8, {8'hFF, valid8}, {8'h0, plru8});
      if (i == 0) chk("w8_plan_model", ev, 6);
      @(negedge clk);
      miss_req8 = 1'b0;
      #1;
      chk("w8_victim", victim8, ev);
      chk("w8_fill", {rd8, wr8}, 2'b10);
      chk("w8_addr", addr8, {miss_addr8[15:5], 5'b0});
      pmem_resp8 = 1'b1;
      #1;
      chk("w8_load", load8, 1);
      @(negedge clk);
      pmem_resp8 = 1'b0;
      #1;
      chk("w8_done", done8, 1);
      @(negedge clk);
      #1;
      chk("w8_ready", ready8, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_evict_ctrl.md
Name: cache_evict_ctrl

Overview:
- Parametrised miss/eviction controller for an N-way set-associative cache sitting between the cache datapath and the physical-memory arbiter.
- On an accepted miss, it selects a victim way: the lowest-index invalid way first, otherwise the tree pseudo-LRU victim.
- If the victim is valid and dirty, it writes the line back to memory, then fetches the missed line and signals the datapath to load it.
- All memory addresses are line-aligned.

Parameters:
- WAYS, 4, number of ways; power of 2, 2..16.
- ADDR_W, 16, physical address width.
- TAG_W, 6, tag width.
- OFFSET_W, 5, line offset width. Index width IDX_W = ADDR_W - TAG_W - OFFSET_W, must be ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- miss_req  in  1  miss request, valid level.
- miss_ready  out  1  controller can accept a request.
- miss_addr  in  ADDR_W  missing address.
- tags  in  WAYS*TAG_W  tags of the indexed set; way w occupies bits [w*TAG_W +: TAG_W].
- valid  in  WAYS  valid bits of the indexed set.
- dirty  in  WAYS  dirty bits of the indexed set.
- plru  in  WAYS-1  tree-PLRU bits of the indexed set.
- pmem_read  out  1  memory read request.
- pmem_write  out  1  memory write request.
- pmem_address  out  ADDR_W  line-aligned memory address.
- pmem_resp  in  1  memory completion, one-cycle pulse.
- victim_way  out  $clog2(WAYS)  latched victim way.
- load_line  out  1  datapath writes fill data into victim_way and sets it valid, clean, with the new tag.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, miss_ready=1, pmem_read=0, pmem_write=0, pmem_address=0, victim_way=0, load_line=0, done=0.
- States: IDLE, WB, FILL, DONE. Outputs decode from registered state and latched fields; load_line is the only Mealy output.
- miss_ready=1 only in IDLE.
- Accept: miss_req & miss_ready at a rising edge. In that same edge the block latches:
  - addr_q = miss_addr
  - victim way v
  - vtag_q = tags[v]
  - wb_q = valid[v] & dirty[v]
- Inputs are ignored after acceptance until the block returns to IDLE.
- Victim selection:
  - If any valid bit is 0, v = lowest index with valid=0.
  - Otherwise walk a heap-ordered tree: start at node n=0; bit plru[n]=0 goes left (n=2n+1), 1 goes right (n=2n+2). Repeat for log2(WAYS) levels. Leaves map left-to-right to ways 0..WAYS-1.
  - For WAYS=4: plru 000/100 -> way0; 010/110 -> way1; 001/011 -> way2; 101/111 -> way3.
- Transitions:
  - IDLE -> WB if accept & wb. IDLE -> FILL if accept & !wb.
  - WB: pmem_write=1, pmem_address = {vtag_q, addr_q index field, OFFSET_W zeros}. Hold until pmem_resp, then go to FILL.
  - FILL: pmem_read=1, pmem_address = {addr_q[ADDR_W-1:OFFSET_W], OFFSET_W zeros}. Hold until pmem_resp. load_line = (state==FILL) & pmem_resp. Then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: the first memory request is asserted the cycle after accept. Earliest cycles from accept to done (pmem_resp in the first request cycle): 2 without writeback, 3 with writeback.
- pmem_address=0 in IDLE and DONE.
- pmem_read and pmem_write are never both 1.
- pmem_resp in IDLE or DONE is ignored.
- Reset mid-operation: state returns to IDLE, and all request outputs are 0 in the cycle after the reset edge. No load_line or done is generated. A late pmem_resp is ignored.
- rst has priority over accept in the same cycle.
- victim_way holds its value from accept until the next accept or reset.

Test Plan:
- Reset: assert rst for 2 cycles with miss_req=1 -> all outputs at reset values, miss_ready=1, no accept.
- Clean PLRU miss: WAYS=4, valid=1111, dirty=0000, plru=3'b010, miss_addr=16'hABCD; pmem_resp 3 cycles after pmem_read rises -> victim_way=1, no pmem_write, pmem_read with pmem_address=16'hABC0, load_line in the pmem_resp cycle, done on the next cycle, miss_ready=1 on the cycle after that.
- Dirty writeback: valid=1111, dirty=1000, plru=3'b101, tags[3]=6'h15, miss_addr=16'hABCD -> victim_way=3; pmem_write with address 16'h57C0 until pmem_resp; next cycle pmem_read with 16'hABC0; load_line then done; read and write are never overlapped.
- Invalid priority: valid=1011, dirty=1111, plru=000 -> victim_way=2, direct FILL, no writeback.
- Input isolation: after accept, change miss_addr, tags and plru, and pulse miss_req during WB -> addresses unchanged, miss_ready=0, no second accept.
- Reset mid-WB: rst while pmem_write=1, then pmem_resp the next cycle -> pmem_write=0 after the reset edge, state IDLE, no load_line or done. WAYS=8 variant with plru=7'b0000101 and all valid -> victim_way=6.
